hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised successor to the per-stage Tuse/Tnew stall unit. Sits beside the D stage of the pipeline.
//  It keeps a per-register countdown scoreboard of pending results, so stall no longer depends on decoding E/M instructions.
//  It also owns the mult/div busy timer and the EPC write-before-eret interlock, and reports the cause of every stall.
// PARAMETERS
//  NREG        32  architectural GPR count; AW=$clog2(NREG)
//  TW          3   width of Tuse/Tnew fields and of the countdowns
//  MULT_CYCLES 5   MDU busy cycles for mult/multu/madd
//  DIV_CYCLES  10  MDU busy cycles for div/divu
//  EPC_LAT     2   cycles from mtc0 leaving D until EPC is visible to eret in D
// PORTS
//  clk          in  1      clock
//  reset        in  1      synchronous, active-high
//  freeze       in  1      global pipeline hold (bus wait); all state holds
//  flush        in  1      exception/eret flush of the E and M stages
//  d_valid      in  1      D holds a real instruction
//  d_rs, d_rt   in  AW     source registers (0 = unused)
//  d_tuse_rs    in  TW     Tuse of rs (7 = never used)
//  d_tuse_rt    in  TW     Tuse of rt
//  d_dst        in  AW     destination register (0 = none)
//  d_tnew       in  TW     Tnew at E entry (calc/mf 1, load/mfc0 2)
//  d_md_start   in  1      mult/div start op; d_md_div=1 selects DIV_CYCLES
//  d_md_div     in  1
//  d_md_access  in  1      mult/div, mt or mf op (must wait for MDU)
//  d_mtc0_epc   in  1      mtc0 writing CP0 reg 14
//  d_eret       in  1
//  stall        out 1      hold F/D, insert bubble into E
//  stall_cause  out 4      {eret, md, rt, rs}; one-hot or multi-hot
//  md_busy      out 1      MDU timer non-zero
//  pend_mask    out NREG   bit i = countdown[i] != 0 (debug/verification)
// BEHAVIOUR
//  - reset: all countdowns, the MDU timer, md_in_e and the EPC timer are cleared to 0. stall, stall_cause, md_busy and pend_mask read 0.
//  - issue = d_valid & ~stall & ~freeze. All outputs are combinational from the current state and D inputs. There is no output latency.
//  - Scoreboard: cnt[NREG], each TW bits wide. Every non-frozen cycle, each non-zero cnt decrements by 1.
//    - On issue with d_dst != 0, cnt[d_dst] <= d_tnew. This overrides the decrement (WAW: the newest producer wins).
//    - cnt[0] is always 0.
//  - rs hazard = d_valid & d_rs != 0 & cnt[d_rs] > d_tuse_rs. The rt hazard is defined the same way on rt.
//  - MDU: on issue with d_md_start, the timer is loaded with (d_md_div ? DIV_CYCLES : MULT_CYCLES) + 1, and md_in_e is set for 1 cycle.
//    - Otherwise the timer decrements to 0.
//    - md hazard = d_valid & d_md_access & timer != 0.
//  - EPC: on issue with d_mtc0_epc, epc_t <= EPC_LAT. Otherwise it decrements.
//    - eret hazard = d_valid & d_eret & epc_t != 0.
//  - stall = OR of the four hazards. stall_cause gives the individual terms.
//  - freeze: every counter holds and no issue occurs. stall is still computed and driven.
//  - flush (has priority over issue and decrement):
//    - all cnt <= 0 and epc_t <= 0 (producers in E/M are killed).
//    - MDU timer <= 0 only if md_in_e is set (the op was killed before it started); otherwise the timer keeps counting.
//    - md_in_e <= 0.
//  - flush with freeze: flush wins.
//  - reset mid-operation clears everything on the next edge regardless of freeze/flush.
//  - Counters saturate at 0 and never wrap. d_tnew is applied as given (caller bounds it below 2^TW).
// TESTING
//  - lw $1 issued, then addu $2,$1,$3 in D (tuse 1): stall=1 for 1 cycle, cause=4'b0001, then issue. cnt[1] goes 2,1,0.
//  - addu $1 issued, then beq $1,$2 (tuse 0): 1 stall cycle. With one nop between them: 0 stall cycles.
//  - lw $4 issued, then ori $4 issued (WAW), then sw using $4 as rt (tuse 2): no stall, cnt[4]=1 at the ori issue.
//  - div issued, then mflo in D: stall for 11 cycles with cause=4'b0100 and md_busy=1, then issue. Repeat with mult: 6 cycles.
//  - mtc0 $14 issued, then eret in D: stall 2 cycles, cause=4'b1000. With flush asserted in the cycle after the mtc0: stall drops next cycle.
//  - Ops with d_rs=0 or d_dst=0 never stall or set pend_mask[0]. freeze for 3 cycles keeps pend_mask constant. reset during a div clears md_busy next cycle.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// D-stage hazard scoreboard: per-register result countdowns, MDU busy timer and
// EPC-before-eret interlock, with a per-cause stall report.
module hazard_scoreboard #(
    parameter int NREG        = 32,
    parameter int TW          = 3,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int EPC_LAT     = 2,
    parameter int AW          = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            freeze,
    input  logic            flush,
    input  logic            d_valid,
    input  logic [AW-1:0]   d_rs,
    input  logic [AW-1:0]   d_rt,
    input  logic [TW-1:0]   d_tuse_rs,
    input  logic [TW-1:0]   d_tuse_rt,
    input  logic [AW-1:0]   d_dst,
    input  logic [TW-1:0]   d_tnew,
    input  logic            d_md_start,
    input  logic            d_md_div,
    input  logic            d_md_access,
    input  logic            d_mtc0_epc,
    input  logic            d_eret,
    output logic            stall,
    output logic [3:0]      stall_cause,
    output logic            md_busy,
    output logic [NREG-1:0] pend_mask
);

    localparam int MD_MAX = ((DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES) + 1;
    localparam int MW     = $clog2(MD_MAX + 1);
    localparam int EW     = $clog2(EPC_LAT + 2);

    logic [TW-1:0] cnt_q [NREG];
    logic [TW-1:0] cnt_d [NREG];
    logic [MW-1:0] md_t_q, md_t_d;
    logic          md_in_e_q, md_in_e_d;
    logic [EW-1:0] epc_t_q, epc_t_d;
    logic          haz_rs_s, haz_rt_s, haz_md_s, haz_eret_s, issue_s;
    logic [MW-1:0] md_load_s;

    function automatic logic [MW-1:0] dec_md(input logic [MW-1:0] v);
        return (v != '0) ? (v - MW'(1)) : '0;
    endfunction

    function automatic logic [EW-1:0] dec_epc(input logic [EW-1:0] v);
        return (v != '0) ? (v - EW'(1)) : '0;
    endfunction

    // A source is late when its producer needs more cycles than the consumer can wait.
    assign haz_rs_s    = d_valid & (d_rs != '0) & (cnt_q[d_rs] > d_tuse_rs);
    assign haz_rt_s    = d_valid & (d_rt != '0) & (cnt_q[d_rt] > d_tuse_rt);
    assign haz_md_s    = d_valid & d_md_access & (md_t_q != '0);
    assign haz_eret_s  = d_valid & d_eret & (epc_t_q != '0);
    assign stall       = haz_rs_s | haz_rt_s | haz_md_s | haz_eret_s;
    assign stall_cause = {haz_eret_s, haz_md_s, haz_rt_s, haz_rs_s};
    assign md_busy     = (md_t_q != '0);
    assign issue_s     = d_valid & ~stall & ~freeze;
    assign md_load_s   = d_md_div ? MW'(DIV_CYCLES + 1) : MW'(MULT_CYCLES + 1);

    // Debug view of which registers still have a result in flight.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            pend_mask[i] = (cnt_q[i] != '0);
        end
    end

    // Next-state: flush beats freeze, freeze beats issue/decrement.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        md_t_d    = md_t_q;
        md_in_e_d = md_in_e_q;
        epc_t_d   = epc_t_q;
        if (flush) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_d[i] = '0;
            end
            epc_t_d   = '0;
            md_in_e_d = 1'b0;
            // An op still in E never reached the MDU, so its timer is void.
            if (md_in_e_q) begin
                md_t_d = '0;
            end else begin
                md_t_d = dec_md(md_t_q);
            end
        end else if (!freeze) begin
            for (int i = 1; i < NREG; i++) begin
                cnt_d[i] = (issue_s && (d_dst == AW'(i))) ? d_tnew :
                           ((cnt_q[i] != '0) ? (cnt_q[i] - TW'(1)) : '0);
            end
            if (issue_s && d_md_start) begin
                md_t_d = md_load_s;
            end else begin
                md_t_d = dec_md(md_t_q);
            end
            md_in_e_d = issue_s & d_md_start;
            if (issue_s && d_mtc0_epc) begin
                epc_t_d = EW'(EPC_LAT);
            end else begin
                epc_t_d = dec_epc(epc_t_q);
            end
        end else begin
            md_in_e_d = md_in_e_q;
        end
        cnt_d[0] = '0;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
            md_t_q    <= '0;
            md_in_e_q <= 1'b0;
            epc_t_q   <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            md_t_q    <= md_t_d;
            md_in_e_q <= md_in_e_d;
            epc_t_q   <= epc_t_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus random traffic,
// checked every cycle against a ready-time reference model.
module tb_hazard_scoreboard;

    logic        clk, reset, freeze, flush, d_valid;
    logic [4:0]  d_rs, d_rt, d_dst;
    logic [2:0]  d_tuse_rs, d_tuse_rt, d_tnew;
    logic        d_md_start, d_md_div, d_md_access, d_mtc0_epc, d_eret;
    logic        stall, md_busy;
    logic [3:0]  stall_cause;
    logic [31:0] pend_mask;

    int tests = 0;
    int fails = 0;

    // Reference model: absolute "ready" times on a clock that only advances when state moves.
    int now;
    int ready_at [32];
    int md_ready, epc_ready, md_start_t;

    logic       last_stall, last_busy;
    logic [3:0] last_cause;
    logic [31:0] last_mask;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset), .freeze(freeze), .flush(flush),
        .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_dst(d_dst), .d_tnew(d_tnew),
        .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_access(d_md_access),
        .d_mtc0_epc(d_mtc0_epc), .d_eret(d_eret),
        .stall(stall), .stall_cause(stall_cause), .md_busy(md_busy), .pend_mask(pend_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rem(input int t);
        return (t > now) ? (t - now) : 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) ready_at[i] = now;
        md_ready   = now;
        epc_ready  = now;
        md_start_t = -10;
    endtask

    task automatic idle();
        d_valid = 1'b0; d_rs = 5'd0; d_rt = 5'd0; d_dst = 5'd0;
        d_tuse_rs = 3'd7; d_tuse_rt = 3'd7; d_tnew = 3'd0;
        d_md_start = 1'b0; d_md_div = 1'b0; d_md_access = 1'b0;
        d_mtc0_epc = 1'b0; d_eret = 1'b0;
    endtask

    task automatic set_op(input int rs, input int trs, input int rt, input int trt,
                          input int dst, input int tnew, input bit mds, input bit mdd,
                          input bit mda, input bit mtc, input bit er);
        d_valid = 1'b1;
        d_rs = 5'(rs); d_tuse_rs = 3'(trs);
        d_rt = 5'(rt); d_tuse_rt = 3'(trt);
        d_dst = 5'(dst); d_tnew = 3'(tnew);
        d_md_start = mds; d_md_div = mdd; d_md_access = mda;
        d_mtc0_epc = mtc; d_eret = er;
    endtask

    // One cycle: check outputs mid-cycle against the model, then advance the model.
    task automatic tick();
        logic        e_rs, e_rt, e_md, e_er, e_stall, e_busy, iss, md_in_e;
        logic [31:0] e_mask;
        #1;
        e_rs   = d_valid && (d_rs != 5'd0) && (rem(ready_at[d_rs]) > int'(d_tuse_rs));
        e_rt   = d_valid && (d_rt != 5'd0) && (rem(ready_at[d_rt]) > int'(d_tuse_rt));
        e_busy = (rem(md_ready) != 0);
        e_md   = d_valid && d_md_access && e_busy;
        e_er   = d_valid && d_eret && (rem(epc_ready) != 0);
        e_stall = e_rs | e_rt | e_md | e_er;
        e_mask = 32'd0;
        for (int i = 1; i < 32; i++) e_mask[i] = (rem(ready_at[i]) != 0);
        chk("stall", stall, e_stall);
        chk("stall_cause", stall_cause, {e_er, e_md, e_rt, e_rs});
        chk("md_busy", md_busy, e_busy);
        chk("pend_mask", pend_mask, e_mask);
        last_stall = stall; last_cause = stall_cause; last_busy = md_busy; last_mask = pend_mask;
        iss     = d_valid && !e_stall && !freeze;
        md_in_e = (md_start_t == now - 1);
        if (reset) begin
            model_clear();
        end else if (flush) begin
            for (int i = 0; i < 32; i++) ready_at[i] = now;
            epc_ready = now;
            if (md_in_e) md_ready = now;
            md_start_t = -10;
            now++;
        end else if (!freeze) begin
            if (iss && d_dst != 5'd0) ready_at[d_dst] = now + 1 + int'(d_tnew);
            if (iss && d_md_start) begin
                md_ready   = now + 1 + (d_md_div ? 10 : 5) + 1;
                md_start_t = now;
            end
            if (iss && d_mtc0_epc) epc_ready = now + 1 + 2;
            now++;
        end
        @(negedge clk);
    endtask

    // Hold the current D instruction until it issues; report stall cycles and first cause.
    task automatic run_issue(input string tag, output int n, output logic [3:0] c0);
        bit done;
        n = 0; c0 = 4'd0; done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            tick();
            if (last_stall) begin
                if (n == 0) c0 = last_cause;
                n++;
            end else begin
                done = 1'b1;
            end
        end
        chk({tag, "_issue_bound"}, done, 1'b1);
        idle();
    endtask

    task automatic drain(input int n);
        idle();
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int n;
        logic [3:0] c;
        now = 0;
        reset = 1'b1; freeze = 1'b0; flush = 1'b0;
        idle();
        @(negedge clk);
        @(negedge clk);
        model_clear();
        reset = 1'b0;

        tick();
        chk("reset_stall", last_stall, 1'b0);
        chk("reset_mask", last_mask, 32'd0);
        chk("reset_busy", last_busy, 1'b0);

        // lw $1 then addu $2,$1,$3
        set_op(0, 7, 0, 7, 1, 2, 0, 0, 0, 0, 0); run_issue("lw", n, c);
        set_op(1, 1, 3, 1, 2, 1, 0, 0, 0, 0, 0); run_issue("addu", n, c);
        chk("lw_use_stalls", n, 1);
        chk("lw_use_cause", c, 4'b0001);
        drain(4);

        // addu $1 then beq $1,$2; then with a nop between
        set_op(0, 7, 0, 7, 1, 1, 0, 0, 0, 0, 0); run_issue("addu1", n, c);
        set_op(1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0); run_issue("beq", n, c);
        chk("beq_stalls", n, 1);
        drain(4);
        set_op(0, 7, 0, 7, 1, 1, 0, 0, 0, 0, 0); run_issue("addu2", n, c);
        drain(1);
        set_op(1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0); run_issue("beq_nop", n, c);
        chk("beq_nop_stalls", n, 0);
        drain(4);

        // WAW: lw $4, ori $4, sw with $4 as rt
        set_op(0, 7, 0, 7, 4, 2, 0, 0, 0, 0, 0); run_issue("lw4", n, c);
        set_op(0, 7, 0, 7, 4, 1, 0, 0, 0, 0, 0); run_issue("ori4", n, c);
        set_op(0, 7, 4, 2, 0, 0, 0, 0, 0, 0, 0); run_issue("sw4", n, c);
        chk("waw_sw_stalls", n, 0);
        drain(4);

        // div/mflo then mult/mflo
        set_op(0, 7, 0, 7, 0, 0, 1, 1, 1, 0, 0); run_issue("div", n, c);
        set_op(0, 7, 0, 7, 5, 1, 0, 0, 1, 0, 0); run_issue("mflo_div", n, c);
        chk("div_stalls", n, 11);
        chk("div_cause", c, 4'b0100);
        drain(4);
        set_op(0, 7, 0, 7, 0, 0, 1, 0, 1, 0, 0); run_issue("mult", n, c);
        chk("mult_busy", md_busy, 1'b1);
        set_op(0, 7, 0, 7, 5, 1, 0, 0, 1, 0, 0); run_issue("mflo_mult", n, c);
        chk("mult_stalls", n, 6);
        drain(4);

        // mtc0 EPC then eret; then the flushed variant
        set_op(0, 7, 0, 7, 0, 0, 0, 0, 0, 1, 0); run_issue("mtc0", n, c);
        set_op(0, 7, 0, 7, 0, 0, 0, 0, 0, 0, 1); run_issue("eret", n, c);
        chk("eret_stalls", n, 2);
        chk("eret_cause", c, 4'b1000);
        drain(4);
        set_op(0, 7, 0, 7, 0, 0, 0, 0, 0, 1, 0); run_issue("mtc0f", n, c);
        set_op(0, 7, 0, 7, 0, 0, 0, 0, 0, 0, 1);
        flush = 1'b1;
        tick();
        chk("eret_flush_cyc1", last_stall, 1'b1);
        flush = 1'b0;
        tick();
        chk("eret_flush_cyc2", last_stall, 1'b0);
        drain(4);

        // Register 0 never pends or stalls
        set_op(0, 7, 0, 7, 0, 2, 0, 0, 0, 0, 0); run_issue("dst0", n, c);
        set_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); run_issue("rs0", n, c);
        chk("rs0_stalls", n, 0);
        chk("r0_mask", last_mask, 32'd0);
        drain(2);

        // Freeze holds pend_mask
        set_op(0, 7, 0, 7, 5, 2, 0, 0, 0, 0, 0); run_issue("lw5", n, c);
        freeze = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("freeze_mask", last_mask, 32'h0000_0020);
        end
        freeze = 1'b0;
        drain(4);

        // Reset during div
        set_op(0, 7, 0, 7, 0, 0, 1, 1, 1, 0, 0); run_issue("div_r", n, c);
        drain(2);
        chk("div_busy_before_reset", last_busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("reset_clears_busy", last_busy, 1'b0);

        // Random traffic
        for (int k = 0; k < 800; k++) begin
            reset  = ($urandom_range(0, 99) == 0);
            freeze = ($urandom_range(0, 7) == 0);
            flush  = ($urandom_range(0, 15) == 0);
            d_valid     = ($urandom_range(0, 3) != 0);
            d_rs        = 5'($urandom_range(0, 7));
            d_rt        = 5'($urandom_range(0, 7));
            d_tuse_rs   = 3'($urandom_range(0, 7));
            d_tuse_rt   = 3'($urandom_range(0, 7));
            d_dst       = 5'($urandom_range(0, 7));
            d_tnew      = 3'($urandom_range(0, 7));
            d_md_start  = ($urandom_range(0, 7) == 0);
            d_md_div    = $urandom_range(0, 1) != 0;
            d_md_access = ($urandom_range(0, 3) == 0);
            d_mtc0_epc  = ($urandom_range(0, 7) == 0);
            d_eret      = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
